// File: rtl/ttl_sync_edge.sv
// Single-bit synchroniser chain followed by an edge detector.
// Reset loads the chain with RST_VAL and the previous-value register with POL so no edge appears right after reset.
module ttl_sync_edge #(
  parameter int unsigned STAGES  = 0,
  parameter bit          RST_VAL = 1'b1,
  parameter bit          POL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic edge_det
);

  logic prev;

  generate
    if (STAGES == 0) begin : g_direct
      assign dout = din;
    end else begin : g_chain
      logic [STAGES-1:0] chain;
      always_ff @(posedge clk) begin
        if (rst) begin
          chain <= {STAGES{RST_VAL}};
        end else begin
          chain[0] <= din;
          for (int j = 1; j < STAGES; j++) chain[j] <= chain[j-1];
        end
      end
      assign dout = chain[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) prev <= POL;
    else     prev <= dout;
  end

  assign edge_det = POL ? (dout & ~prev) : (~dout & prev);

endmodule

// File: rtl/ttl_7474_sync.sv
// BLOCKS independent 7474-style D flip-flops whose Clk pins are sampled data, all running on the one system clock.
// Preset and clear win over a captured edge; both asserted drives Q and Q_bar high together.
module ttl_7474_sync #(
  parameter int unsigned       BLOCKS      = 2,
  parameter int unsigned       SYNC_STAGES = 0,
  parameter logic [BLOCKS-1:0] CLK_POL     = {BLOCKS{1'b1}},
  parameter logic [BLOCKS-1:0] INIT        = {BLOCKS{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BLOCKS-1:0] Preset_bar,
  input  logic [BLOCKS-1:0] Clear_bar,
  input  logic [BLOCKS-1:0] D,
  input  logic [BLOCKS-1:0] Clk,
  output logic [BLOCKS-1:0] Q,
  output logic [BLOCKS-1:0] Q_bar,
  output logic [BLOCKS-1:0] Clk_edge
);

  genvar i;
  generate
    for (i = 0; i < BLOCKS; i++) begin : g_blk
      logic clk_s, pre_s, clr_s, edge_hit;
      logic pre_edge_unused, clr_edge_unused;
      logic q_r, both_r, edge_r;

      ttl_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CLK_POL[i]), .POL(CLK_POL[i])) u_clk (
        .clk(clk), .rst(rst), .din(Clk[i]), .dout(clk_s), .edge_det(edge_hit)
      );
      ttl_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .POL(1'b1)) u_pre (
        .clk(clk), .rst(rst), .din(Preset_bar[i]), .dout(pre_s), .edge_det(pre_edge_unused)
      );
      ttl_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .POL(1'b1)) u_clr (
        .clk(clk), .rst(rst), .din(Clear_bar[i]), .dout(clr_s), .edge_det(clr_edge_unused)
      );

      // An edge seen while preset/clear is held is dropped, but the strobe still reports it.
      always_ff @(posedge clk) begin
        if (rst) begin
          q_r    <= INIT[i];
          both_r <= 1'b0;
          edge_r <= 1'b0;
        end else begin
          edge_r <= edge_hit;
          if (!pre_s && !clr_s) begin
            q_r    <= 1'b1;
            both_r <= 1'b1;
          end else if (!pre_s) begin
            q_r    <= 1'b1;
            both_r <= 1'b0;
          end else if (!clr_s) begin
            q_r    <= 1'b0;
            both_r <= 1'b0;
          end else begin
            both_r <= 1'b0;
            if (edge_hit) q_r <= D[i];
          end
        end
      end

      assign Q[i]        = q_r | both_r;
      assign Q_bar[i]    = ~q_r | both_r;
      assign Clk_edge[i] = edge_r;
    end
  endgenerate

endmodule

// File: tb/tb_ttl_7474_sync.sv
// Bench for ttl_7474_sync: directed vector table on a 2-block unsynchronised instance, hand sequences
// for synchroniser latency on a 4-block 2-stage instance, then random traffic against a reference model.
module tb_ttl_7474_sync;

  localparam logic [1:0] POL0  = 2'b01;
  localparam logic [1:0] INIT0 = 2'b01;
  localparam logic [3:0] POL2  = 4'b1011;
  localparam logic [3:0] INIT2 = 4'b0110;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pre0, clr0, d0, k0, q0, qb0, e0;
  logic [3:0] pre2, clr2, d2, k2, q2, qb2, e2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ttl_7474_sync #(.BLOCKS(2), .SYNC_STAGES(0), .CLK_POL(POL0), .INIT(INIT0)) dut0 (
    .clk(clk), .rst(rst), .Preset_bar(pre0), .Clear_bar(clr0), .D(d0), .Clk(k0),
    .Q(q0), .Q_bar(qb0), .Clk_edge(e0)
  );
  ttl_7474_sync #(.BLOCKS(4), .SYNC_STAGES(2), .CLK_POL(POL2), .INIT(INIT2)) dut2 (
    .clk(clk), .rst(rst), .Preset_bar(pre2), .Clear_bar(clr2), .D(d2), .Clk(k2),
    .Q(q2), .Q_bar(qb2), .Clk_edge(e2)
  );

  // Reference model: per flip-flop, the pins it "sees" are the raw pins delayed by S clk cycles.
  bit mq[2][4], mboth[2][4], mprev[2][4], medge[2][4];
  bit hk[2][4][3], hp[2][4][3], hc[2][4][3];

  task automatic model_step(input int u);
    int  nb  = (u == 0) ? 2 : 4;
    int  s   = (u == 0) ? 0 : 2;
    logic [3:0] pol  = (u == 0) ? {2'b00, POL0}  : POL2;
    logic [3:0] init = (u == 0) ? {2'b00, INIT0} : INIT2;
    logic [3:0] pin_p = (u == 0) ? {2'b11, pre0} : pre2;
    logic [3:0] pin_c = (u == 0) ? {2'b11, clr0} : clr2;
    logic [3:0] pin_d = (u == 0) ? {2'b00, d0}   : d2;
    logic [3:0] pin_k = (u == 0) ? {2'b00, k0}   : k2;
    for (int b = 0; b < nb; b++) begin
      if (rst) begin
        mq[u][b] = init[b]; mboth[u][b] = 0; medge[u][b] = 0; mprev[u][b] = pol[b];
        for (int j = 0; j < 3; j++) begin
          hk[u][b][j] = pol[b]; hp[u][b][j] = 1; hc[u][b][j] = 1;
        end
      end else begin
        bit ks, ps, cs, hit;
        ks = (s == 0) ? pin_k[b] : hk[u][b][s-1];
        ps = (s == 0) ? pin_p[b] : hp[u][b][s-1];
        cs = (s == 0) ? pin_c[b] : hc[u][b][s-1];
        hit = pol[b] ? (ks && !mprev[u][b]) : (!ks && mprev[u][b]);
        if (!ps && !cs)   begin mq[u][b] = 1; mboth[u][b] = 1; end
        else if (!ps)     begin mq[u][b] = 1; mboth[u][b] = 0; end
        else if (!cs)     begin mq[u][b] = 0; mboth[u][b] = 0; end
        else begin
          mboth[u][b] = 0;
          if (hit) mq[u][b] = pin_d[b];
        end
        medge[u][b] = hit;
        mprev[u][b] = ks;
        for (int j = 2; j > 0; j--) begin
          hk[u][b][j] = hk[u][b][j-1]; hp[u][b][j] = hp[u][b][j-1]; hc[u][b][j] = hc[u][b][j-1];
        end
        hk[u][b][0] = pin_k[b]; hp[u][b][0] = pin_p[b]; hc[u][b][0] = pin_c[b];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    logic [3:0] eq, eqb, ee;
    for (int u = 0; u < 2; u++) begin
      eq = '0; eqb = '0; ee = '0;
      for (int b = 0; b < ((u == 0) ? 2 : 4); b++) begin
        eq[b]  = mq[u][b] | mboth[u][b];
        eqb[b] = ~mq[u][b] | mboth[u][b];
        ee[b]  = medge[u][b];
      end
      if (u == 0) begin
        chk("rand_q0", {2'b00, q0}, eq); chk("rand_qb0", {2'b00, qb0}, eqb); chk("rand_e0", {2'b00, e0}, ee);
      end else begin
        chk("rand_q2", q2, eq); chk("rand_qb2", qb2, eqb); chk("rand_e2", e2, ee);
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] pre, clr, d, k;
    logic [1:0] eq, eqb, ee;
  } vec_t;

  vec_t v[18];

  initial begin
    // block0 rising INIT 1, block1 falling INIT 0
    v[0]  = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
    v[1]  = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00};
    v[2]  = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10};
    v[3]  = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01};
    v[4]  = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b11, 2'b00};
    v[5]  = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00};
    v[6]  = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b10, 2'b01};
    v[7]  = '{1'b0, 2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00};
    v[8]  = '{1'b0, 2'b11, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10};
    v[9]  = '{1'b0, 2'b11, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00};
    v[10] = '{1'b0, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01};
    v[11] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00};
    v[12] = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
    v[13] = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
    v[14] = '{1'b1, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b10, 2'b00};
    v[15] = '{1'b0, 2'b11, 2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b00};
    v[16] = '{1'b0, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
    v[17] = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00};

    rst = 1'b1;
    pre0 = '1; clr0 = '1; d0 = '0; k0 = '1;
    pre2 = '1; clr2 = '1; d2 = '0; k2 = POL2;
    #2;

    for (int n = 0; n < 18; n++) begin
      rst = v[n].rst; pre0 = v[n].pre; clr0 = v[n].clr; d0 = v[n].d; k0 = v[n].k;
      step();
      chk($sformatf("vec%0d_q", n),    {2'b00, q0},  {2'b00, v[n].eq});
      chk($sformatf("vec%0d_qbar", n), {2'b00, qb0}, {2'b00, v[n].eqb});
      chk($sformatf("vec%0d_edge", n), {2'b00, e0},  {2'b00, v[n].ee});
    end

    // Two-stage preset latency on dut2 block0 (INIT 0)
    rst = 1'b1; k2 = POL2; d2 = '0; pre2 = '1; clr2 = '1;
    step();
    rst = 1'b0;
    step();
    pre2[0] = 1'b0;
    step(); chk("sync_pre_e1", {3'b000, q2[0]}, 4'd0);
    step(); chk("sync_pre_e2", {3'b000, q2[0]}, 4'd0);
    step(); chk("sync_pre_e3", {3'b000, q2[0]}, 4'd1);
    pre2[0] = 1'b1; clr2[0] = 1'b0;
    repeat (3) step();
    chk("sync_clr", {3'b000, q2[0]}, 4'd0);
    clr2[0] = 1'b1; k2[0] = 1'b0;
    repeat (4) step();
    chk("sync_idle", {3'b000, q2[0]}, 4'd0);

    // Two-stage Clk latency: rising pin at this edge, capture two edges later
    k2[0] = 1'b1; d2[0] = 1'b1;
    step(); chk("sync_clk_e1", {3'b000, q2[0]}, 4'd0);
    step(); chk("sync_clk_e2", {3'b000, q2[0]}, 4'd0);
    step(); chk("sync_clk_e3", {3'b000, q2[0]}, 4'd1);
    chk("sync_clk_strobe", {3'b000, e2[0]}, 4'd1);
    step(); chk("sync_clk_strobe_off", {3'b000, e2[0]}, 4'd0);

    // Random traffic on both instances against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(299) == 0);
      for (int b = 0; b < 4; b++) begin
        if (b < 2) begin
          if ($urandom_range(2) == 0) k0[b] = ~k0[b];
          d0[b]   = 1'($urandom);
          pre0[b] = ($urandom_range(9) != 0);
          clr0[b] = ($urandom_range(9) != 0);
        end
        if ($urandom_range(2) == 0) k2[b] = ~k2[b];
        d2[b]   = 1'($urandom);
        pre2[b] = ($urandom_range(9) != 0);
        clr2[b] = ($urandom_range(9) != 0);
      end
      step();
      chk_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
